// File: rtl/dmem_lsu_ram_pkg.sv
// Shared definitions for the MEM-stage data memory: size codes, polarity
// constants and the byte-mask / load-extension helpers.
package dmem_lsu_ram_pkg;

    localparam logic [1:0]  SizeByte    = 2'd0;
    localparam logic [1:0]  SizeHalf    = 2'd1;
    localparam logic [1:0]  SizeWord    = 2'd2;

    localparam logic        RstEnable   = 1'b1;
    localparam logic        WriteEnable = 1'b1;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    // Helpers work on the widest supported word; callers size-cast the result.
    localparam int MaxDataW = 64;
    localparam int MaxBytes = MaxDataW / 8;

    typedef enum logic {
        RspEmpty = 1'b0,
        RspFull  = 1'b1
    } rsp_state_e;

    function automatic logic [MaxBytes-1:0] byte_mask(input logic [1:0]  size,
                                                      input logic [31:0] off);
        logic [MaxBytes-1:0] m;
        case (size)
            SizeByte: m = MaxBytes'(1) << off;
            SizeHalf: m = MaxBytes'(3) << off;
            default:  m = '1;
        endcase
        return m;
    endfunction

    function automatic logic [MaxDataW-1:0] load_ext(input logic [MaxDataW-1:0] d,
                                                     input logic [1:0]          size,
                                                     input logic                uns);
        logic [MaxDataW-1:0] r;
        case (size)
            SizeByte: r = {{(MaxDataW-8){d[7] & ~uns}}, d[7:0]};
            SizeHalf: r = {{(MaxDataW-16){d[15] & ~uns}}, d[15:0]};
            default:  r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_lsu_ram_bank.sv
// DEPTH x DATA_W storage with per-byte write strobes and a registered read port.
// The read register only updates on an enabled load, so it holds during stalls.
module dmem_bank
    import dmem_lsu_ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096
) (
    input  logic                     clk,
    input  logic                     i_en,
    input  logic                     i_we,
    input  logic [DATA_W/8-1:0]      i_be,
    input  logic [$clog2(DEPTH)-1:0] i_idx,
    input  logic [DATA_W-1:0]        i_wdat,
    output logic [DATA_W-1:0]        o_rdat
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdat;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we == WriteEnable) begin
                for (int b = 0; b < NB; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_idx][b*8 +: 8] <= i_wdat[b*8 +: 8];
                    end
                end
            end else begin
                r_rdat <= r_mem[i_idx];
            end
        end
    end

    assign o_rdat = r_rdat;

endmodule

// File: rtl/dmem_lsu_ram.sv
// Load/store front end: decode, error checks, lane steering, extension and a
// one-entry response register (1-cycle latency, stalls requests while held).
module dmem_lsu_ram
    import dmem_lsu_ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int HI    = IDX_W + OFF_W;

    logic [OFF_W-1:0]  w_off;
    logic [IDX_W-1:0]  w_idx;
    logic              w_oor;
    logic              w_err;
    logic              w_acc;
    logic [NB-1:0]     w_be;
    logic [DATA_W-1:0] w_wdat;
    logic [DATA_W-1:0] w_bank_rdat;
    logic [DATA_W-1:0] w_shift;
    logic [DATA_W-1:0] w_ext;

    rsp_state_e        r_state;
    logic              r_err;
    logic              r_ld_ok;
    logic [OFF_W-1:0]  r_off;
    logic [1:0]        r_size;
    logic              r_uns;

    assign w_off = i_req_addr[OFF_W-1:0];
    assign w_idx = i_req_addr[HI-1:OFF_W];

    generate
        if (ADDR_W > HI) begin : g_oor
            assign w_oor = |i_req_addr[ADDR_W-1:HI];
        end else begin : g_no_oor
            assign w_oor = 1'b0;
        end
    endgenerate

    assign w_err = (i_req_size == 2'd3)
                || ((i_req_size == SizeHalf) && w_off[0])
                || ((i_req_size == SizeWord) && (w_off != '0))
                || w_oor;

    assign o_rsp_valid = (r_state == RspFull);
    assign o_req_ready = !o_rsp_valid || i_rsp_ready;
    // Requests seen while reset is asserted must not touch the array.
    assign w_acc       = i_req_valid && o_req_ready && (rst != RstEnable);

    assign w_be = NB'(byte_mask(i_req_size, 32'(w_off)));

    always_comb begin
        w_wdat = i_req_wdata;
        case (i_req_size)
            SizeByte: w_wdat = {NB{i_req_wdata[7:0]}};
            SizeHalf: w_wdat = {(NB/2){i_req_wdata[15:0]}};
            default:  w_wdat = i_req_wdata;
        endcase
    end

    dmem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bank (
        .clk    (clk),
        .i_en   (w_acc && !w_err),
        .i_we   (i_req_we),
        .i_be   (w_be),
        .i_idx  (w_idx),
        .i_wdat (w_wdat),
        .o_rdat (w_bank_rdat)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_state <= RspEmpty;
            r_err   <= 1'b0;
            r_ld_ok <= 1'b0;
            r_off   <= '0;
            r_size  <= SizeByte;
            r_uns   <= 1'b0;
        end else if (w_acc) begin
            r_state <= RspFull;
            r_err   <= w_err;
            r_ld_ok <= !i_req_we && !w_err;
            r_off   <= w_off;
            r_size  <= i_req_size;
            r_uns   <= i_req_unsigned;
        end else if ((r_state == RspFull) && i_rsp_ready) begin
            r_state <= RspEmpty;
        end
    end

    // Steering uses the lane info captured with the request, so the output
    // stays stable for as long as the bank's read register is held.
    assign w_shift     = w_bank_rdat >> {r_off, 3'b000};
    assign w_ext       = DATA_W'(load_ext(MaxDataW'(w_shift), r_size, r_uns));
    assign o_rsp_rdata = r_ld_ok ? w_ext : DATA_W'(ZeroWord);
    assign o_rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_lsu_ram.sv
// Directed and randomized checks of dmem_lsu_ram against a byte-addressed
// reference memory built from the access rules.
module tb_dmem_lsu_ram;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4096;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              i_rst;
    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_we;
    logic [1:0]        i_req_size;
    logic              i_req_unsigned;
    logic [ADDR_W-1:0] i_req_addr;
    logic [DATA_W-1:0] i_req_wdata;
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [DATA_W-1:0] o_rsp_rdata;
    logic              o_rsp_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mb [int unsigned];

    dmem_lsu_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst            (i_rst),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_we       (i_req_we),
        .i_req_size     (i_req_size),
        .i_req_unsigned (i_req_unsigned),
        .i_req_addr     (i_req_addr),
        .i_req_wdata    (i_req_wdata),
        .o_rsp_valid    (o_rsp_valid),
        .i_rsp_ready    (i_rsp_ready),
        .o_rsp_rdata    (o_rsp_rdata),
        .o_rsp_err      (o_rsp_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: little-endian byte memory; the access width is 1 << size.
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err);
        int unsigned n;
        n   = 1 << size;
        err = (size == 2'd3) || ((addr % n) != 0) || (addr >= DEPTH * 4);
        rd  = 32'h0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < n; i++) mb[addr + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++)
                    rd[8*i +: 8] = mb.exists(addr + i) ? mb[addr + i] : 8'hxx;
                if (!uns && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8*n));
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic chk_lit, input logic [31:0] lit, input string tag);
        logic [31:0] er;
        logic        ee;
        model(we, size, uns, addr, wd, er, ee);
        check({tag, ":req_ready"}, 32'(o_req_ready), 32'd1);
        i_req_we       = we;
        i_req_size     = size;
        i_req_unsigned = uns;
        i_req_addr     = addr;
        i_req_wdata    = wd;
        i_req_valid    = 1'b1;
        cyc();
        i_req_valid    = 1'b0;
        check({tag, ":rsp_valid"}, 32'(o_rsp_valid), 32'd1);
        check({tag, ":rsp_rdata"}, o_rsp_rdata, er);
        check({tag, ":rsp_err"},   32'(o_rsp_err), 32'(ee));
        if (chk_lit) check({tag, ":literal"}, o_rsp_rdata, lit);
    endtask

    initial begin
        #1_000_000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [1:0]  sz;
        logic [31:0] ad;

        i_rst = 1'b1; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_size = 2'd0;
        i_req_unsigned = 1'b0; i_req_addr = '0; i_req_wdata = '0; i_rsp_ready = 1'b1;
        cyc(); cyc();
        i_rst = 1'b0;
        cyc();
        check("reset:rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("reset:rsp_rdata", o_rsp_rdata, 32'd0);
        check("reset:rsp_err",   32'(o_rsp_err), 32'd0);
        check("reset:req_ready", 32'(o_req_ready), 32'd1);

        // Store then back-to-back sub-word loads with both extensions
        do_req(1, 2'd2, 0, 32'h10, 32'h8000_00F1, 1, 32'h0,         "sw10");
        do_req(0, 2'd0, 0, 32'h10, 32'h0,         1, 32'hFFFF_FFF1, "lb10");
        do_req(0, 2'd0, 1, 32'h10, 32'h0,         1, 32'h0000_00F1, "lbu10");
        do_req(0, 2'd1, 0, 32'h12, 32'h0,         1, 32'hFFFF_8000, "lh12");
        do_req(0, 2'd1, 1, 32'h12, 32'h0,         1, 32'h0000_8000, "lhu12");

        // Byte strobe into an existing word
        do_req(1, 2'd2, 0, 32'h20, 32'h1122_3344, 0, 32'h0,         "sw20");
        do_req(1, 2'd0, 0, 32'h21, 32'h0000_00AB, 0, 32'h0,         "sb21");
        do_req(0, 2'd2, 0, 32'h20, 32'h0,         1, 32'h1122_AB44, "lw20");

        // Error cases leave the array alone
        do_req(0, 2'd1, 0, 32'h13, 32'h0,         1, 32'h0,         "lh13_err");
        do_req(1, 2'd2, 0, 32'h22, 32'hDEAD_BEEF, 1, 32'h0,         "sw22_err");
        do_req(0, 2'd2, 0, 32'h20, 32'h0,         1, 32'h1122_AB44, "lw20_after_err");
        do_req(0, 2'd2, 0, DEPTH*4, 32'h0,        1, 32'h0,         "lw_oor");
        do_req(0, 2'd3, 0, 32'h20, 32'h0,         1, 32'h0,         "size3");

        // Stall: response held, store presented meanwhile must not commit
        do_req(0, 2'd2, 0, 32'h20, 32'h0, 1, 32'h1122_AB44, "lw_prestall");
        i_rsp_ready = 1'b0;
        i_req_we = 1'b1; i_req_size = 2'd2; i_req_addr = 32'h20;
        i_req_wdata = 32'h5A5A_5A5A; i_req_valid = 1'b1;
        #1;
        check("stall:req_ready0", 32'(o_req_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("stall:req_ready", 32'(o_req_ready), 32'd0);
            check("stall:rsp_valid", 32'(o_rsp_valid), 32'd1);
            check("stall:rsp_rdata", o_rsp_rdata, 32'h1122_AB44);
            check("stall:rsp_err",   32'(o_rsp_err), 32'd0);
        end
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        #1;
        do_req(0, 2'd2, 0, 32'h20, 32'h0, 1, 32'h1122_AB44, "release");

        // Drain without a new request
        cyc();
        check("drain:rsp_valid", 32'(o_rsp_valid), 32'd0);

        // Reset with a response pending and a store on the request port
        do_req(0, 2'd2, 0, 32'h20, 32'h0, 1, 32'h1122_AB44, "lw_prerst");
        i_rst = 1'b1;
        i_req_we = 1'b1; i_req_size = 2'd2; i_req_addr = 32'h20;
        i_req_wdata = 32'h5555_5555; i_req_valid = 1'b1;
        cyc();
        i_rst = 1'b0; i_req_valid = 1'b0;
        check("rst_mid:rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("rst_mid:rsp_rdata", o_rsp_rdata, 32'd0);
        check("rst_mid:rsp_err",   32'(o_rsp_err), 32'd0);
        do_req(0, 2'd2, 0, 32'h20, 32'h0, 1, 32'h1122_AB44, "lw_postrst");

        // Randomized traffic over a pre-initialised window
        for (int w = 0; w < 16; w++)
            do_req(1, 2'd2, 0, 32'h100 + 4*w, $urandom, 0, 32'h0, "init");
        for (int k = 0; k < 200; k++) begin
            r  = $urandom_range(0, 15);
            sz = (r < 2) ? 2'd3 : 2'($urandom_range(0, 2));
            if (r == 15)      ad = DEPTH*4 + $urandom_range(0, 255);
            else if (r == 14) ad = 32'h8000_0100;
            else              ad = 32'h100 + $urandom_range(0, 63);
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad,
                   $urandom, 0, 32'h0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
